// File: rtl/uio_dir_ctrl_if.sv
// Control bundle for uio_dir_ctrl.
//   master: drives ena, ser_in, ser_vld and ser_clr; observes uio_oe, busy, done and err.
//   slave : the direction controller itself.
interface uio_dir_ctrl_if;
  logic       ena;
  logic       ser_in;
  logic       ser_vld;
  logic       ser_clr;
  logic [7:0] uio_oe;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output ena, ser_in, ser_vld, ser_clr,
    input  uio_oe, busy, done, err
  );

  modport slave (
    input  ena, ser_in, ser_vld, ser_clr,
    output uio_oe, busy, done, err
  );
endinterface

// File: rtl/uio_dir_ctrl.sv
// uio_dir_ctrl: serially configured output-enable register for 8 bidirectional pins.
// A frame arrives MSB first on ser_in/ser_vld. A direction change passes through a
// break-before-make turnaround of TURN_CYCLES cycles before the new enables are applied.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - uio_dir_ctrl_if.slave (ena, ser_in, ser_vld, ser_clr -> uio_oe, busy, done, err)
//
// Optional feature: define UIO_PARITY_EN for 9-bit frames whose last bit is even parity
// over the 8 data bits; a bad frame pulses err and leaves uio_oe unchanged.
module uio_dir_ctrl #(
  parameter int unsigned TURN_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  uio_dir_ctrl_if.slave bus
);

`ifdef UIO_PARITY_EN
  localparam int unsigned FrameLen = 9;
`else
  localparam int unsigned FrameLen = 8;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StTurn, StApply} state_e;

  state_e     state_q;
  logic [7:0] shadow_q;
  logic [7:0] oe_q;
  logic [3:0] cnt_q;
  logic [3:0] turn_q;
  logic       done_q;
  logic       err_q;

  logic [7:0] shadow_shift;
  logic [7:0] frame_word;
  logic       last_bit;

  assign shadow_shift = {shadow_q[6:0], bus.ser_in};
  assign last_bit     = (cnt_q == 4'(FrameLen - 1));

`ifdef UIO_PARITY_EN
  logic par_ok;
  // The parity bit is not shifted in, so the shadow already holds the full data word.
  assign frame_word = shadow_q;
  assign par_ok     = ~(^{shadow_q, bus.ser_in});
`else
  assign frame_word = shadow_shift;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shadow_q <= 8'h00;
      oe_q     <= 8'h00;
      cnt_q    <= 4'd0;
      turn_q   <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.ena) begin
        unique case (state_q)
          StIdle: begin
            if (bus.ser_vld) begin
              shadow_q <= shadow_shift;
              cnt_q    <= 4'd1;
              state_q  <= StShift;
            end
          end
          StShift: begin
            // Abort beats a simultaneous valid bit.
            if (bus.ser_clr) begin
              cnt_q   <= 4'd0;
              state_q <= StIdle;
            end else if (bus.ser_vld) begin
              if (last_bit) begin
                cnt_q    <= 4'd0;
                shadow_q <= frame_word;
`ifdef UIO_PARITY_EN
                if (!par_ok) begin
                  err_q   <= 1'b1;
                  state_q <= StIdle;
                end else
`endif
                if (frame_word == oe_q) begin
                  state_q <= StApply;
                end else begin
                  // Break-before-make: released pins drop now, claimed pins wait for APPLY.
                  oe_q    <= oe_q & frame_word;
                  turn_q  <= 4'(TURN_CYCLES);
                  state_q <= StTurn;
                end
              end else begin
                shadow_q <= shadow_shift;
                cnt_q    <= cnt_q + 4'd1;
              end
            end
          end
          StTurn: begin
            turn_q <= turn_q - 4'd1;
            if (turn_q <= 4'd1) begin
              state_q <= StApply;
            end
          end
          StApply: begin
            oe_q    <= shadow_q;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.uio_oe = oe_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;
`ifdef UIO_PARITY_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif

endmodule

// File: doc/uio_dir_ctrl.md
UIO_DIR_CTRL -- requirements
Module: uio_dir_ctrl

Interface
REQ-001 Parameter TURN_CYCLES, default 2, range 1..15: number of turnaround cycles between a direction change and its application.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  block enable; when 0 the FSM holds its state and ser_vld is ignored.
REQ-005 ser_in  input  1  serial configuration bit, MSB first.
REQ-006 ser_vld  input  1  ser_in is valid this cycle.
REQ-007 ser_clr  input  1  synchronous abort of a partially shifted frame.
REQ-008 uio_oe  output  8  registered bidirectional-pin output enables, 1 = output.
REQ-009 busy  output  1  high in every state other than IDLE.
REQ-010 done  output  1  one-cycle pulse in the cycle uio_oe takes the new word.
REQ-011 err  output  1  one-cycle pulse on a rejected frame; tied 0 when UIO_PARITY_EN is undefined.

Function
REQ-012 FSM states: IDLE, SHIFT, TURN, APPLY; all encodings outside these four return to IDLE.
REQ-013 IDLE: ser_vld=1 with ena=1 shifts ser_in into an 8-bit shadow register, sets bit count to 1, and moves to SHIFT.
REQ-014 SHIFT: each ser_vld=1 cycle shifts the shadow register left with ser_in entering bit 0 and increments the count; ser_vld=0 cycles hold the shadow register and the count, with no timeout.
REQ-015 Frame length: 8 bits, or 9 bits with UIO_PARITY_EN; when the last bit is accepted, the frame is complete.
REQ-016 Frame complete with shadow == uio_oe: go directly to APPLY.
REQ-017 Frame complete with shadow != uio_oe: go to TURN and load the turnaround counter with TURN_CYCLES.
REQ-018 TURN: uio_oe = old_oe AND new_oe (break-before-make); pins being released drop to 0 on TURN entry, and pins being claimed stay 0.
REQ-019 TURN: decrement the turnaround counter each cycle; after exactly TURN_CYCLES cycles in TURN, move to APPLY.
REQ-020 APPLY lasts one cycle: uio_oe <= shadow, done=1, then return to IDLE.
REQ-021 Latency from the last accepted bit to done: 1 cycle with no direction change; TURN_CYCLES+1 cycles with a direction change.
REQ-022 ser_vld is ignored in TURN and APPLY; bits presented during those states are discarded and are not queued.
REQ-023 ser_clr in SHIFT: clear the count, go to IDLE, leave uio_oe unchanged; ser_clr has no effect in TURN or APPLY.
REQ-024 Simultaneous ser_clr and ser_vld in SHIFT: ser_clr wins and the bit is discarded.
REQ-025 ena=0 freezes the FSM, the counters and uio_oe; done and err are 0 while ena=0.
REQ-026 A new frame may start in the cycle after APPLY.

Reset
REQ-027 While rst_n=0: state=IDLE, uio_oe=8'h00 (all pins inputs), shadow=0, counters=0, busy=0, done=0, err=0.
REQ-028 Reset asserted mid-frame or mid-TURN discards all progress immediately, without waiting for a clock edge.
REQ-029 The first frame after reset is accepted starting from the first clock edge with rst_n=1.

Configuration
REQ-030 Macro UIO_PARITY_EN defined: frames are 9 bits, and the 9th bit is even parity over the 8 data bits.
REQ-031 Parity mismatch: err pulses for 1 cycle in the completion cycle, the FSM goes to IDLE, and uio_oe is unchanged with no TURN.
REQ-032 Macro UIO_PARITY_EN undefined: frames are 8 bits, there is no parity logic, and err is constant 0.

Verification
REQ-033 Reset, then frame 8'hF0 with ser_vld continuous -> uio_oe=00 for 2 cycles (TURN), then F0 with done in the same cycle; done occurs 3 cycles after the last bit.
REQ-034 uio_oe=F0, frame 8'h3C -> during TURN uio_oe=30 for TURN_CYCLES cycles, then 3C with a single done pulse.
REQ-035 uio_oe=3C, frame 8'h3C -> no TURN, done 1 cycle after the last bit, uio_oe stays 3C.
REQ-036 ser_clr after 5 bits, then a full frame 8'h81 -> the first partial frame has no effect, and uio_oe ends at 81.
REQ-037 rst_n pulled low during TURN of an F0->0F change -> uio_oe=00 immediately and busy=0, with no done.
REQ-038 With UIO_PARITY_EN: frame A5 with parity 0 -> applied; frame A5 with parity 1 -> err pulse and uio_oe unchanged.
